// File: rtl/membus_arbiter_if.sv
// Video memory bus bundle: CPU byte port, two read-only layer ports, RAM/ROM ports.
// No latency of its own; it only carries wires.
// Initiators hold requests until ack; the arbiter side never stalls an ack.
interface membus_arbiter_if;
  // CPU register-bus port
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_wrdata;
  logic        cpu_write;
  logic        cpu_strobe;
  logic        cpu_ack;
  logic [7:0]  cpu_rddata;
  // layer renderer ports (read-only)
  logic [17:0] l0_addr;
  logic        l0_strobe;
  logic        l0_ack;
  logic [17:0] l1_addr;
  logic        l1_strobe;
  logic        l1_ack;
  logic [31:0] bus_rddata;
  // memory side
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_bytesel;
  logic        ram_write;
  logic [31:0] ram_rddata;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rddata;

  // arbiter side
  modport slave (
    input  cpu_addr, cpu_wrdata, cpu_write, cpu_strobe,
    input  l0_addr, l0_strobe, l1_addr, l1_strobe,
    input  ram_rddata, rom_rddata,
    output cpu_ack, cpu_rddata, l0_ack, l1_ack, bus_rddata,
    output ram_addr, ram_wrdata, ram_bytesel, ram_write, rom_addr
  );

  // initiator / memory-model side
  modport master (
    output cpu_addr, cpu_wrdata, cpu_write, cpu_strobe,
    output l0_addr, l0_strobe, l1_addr, l1_strobe,
    output ram_rddata, rom_rddata,
    input  cpu_ack, cpu_rddata, l0_ack, l1_ack, bus_rddata,
    input  ram_addr, ram_wrdata, ram_bytesel, ram_write, rom_addr
  );
endinterface

// File: rtl/membus_arbiter.sv
// Single-grant arbiter/responder for video RAM + char ROM shared by CPU and two layers.
// Grant is combinational in cycle N; ack and read data appear in cycle N+1 only.
// No backpressure: a granted access always completes; starving layers preempt the CPU.
module membus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk25,
  input  logic             reset,
  membus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_L0, GNT_L1} gnt_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_ROM} sel_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // registered state: what was granted last cycle and how to return its data
  gnt_t       gnt_q, gnt_d;
  sel_t       sel_q, sel_d;
  logic [1:0] lane_q, lane_d;
  logic       rr_q, rr_d;        // last granted layer: 0 = l0, 1 = l1
  logic [3:0] wait0_q, wait0_d;
  logic [3:0] wait1_q, wait1_d;

  logic        elig_cpu, elig0, elig1;
  logic        starve0, starve1;
  logic [17:0] gaddr;
  logic [31:0] rd_word;
  logic [7:0]  cpu_byte;

  // A port just granted must sit out one cycle, so its strobe in the ack cycle is ignored.
  always_comb begin
    elig_cpu = bus.cpu_strobe && (gnt_q != GNT_CPU);
    elig0    = bus.l0_strobe  && (gnt_q != GNT_L0);
    elig1    = bus.l1_strobe  && (gnt_q != GNT_L1);
    starve0  = elig0 && (wait0_q == LIMIT);
    starve1  = elig1 && (wait1_q == LIMIT);
  end

  // Grant priority: starving layer, then CPU, then any layer; ties between layers go round-robin.
  always_comb begin
    gnt_d = GNT_NONE;
    if (starve0 || starve1) begin
      if (starve0 && starve1)
        gnt_d = rr_q ? GNT_L0 : GNT_L1;
      else
        gnt_d = starve0 ? GNT_L0 : GNT_L1;
    end else if (elig_cpu) begin
      gnt_d = GNT_CPU;
    end else if (elig0 || elig1) begin
      if (elig0 && elig1)
        gnt_d = rr_q ? GNT_L0 : GNT_L1;
      else
        gnt_d = elig0 ? GNT_L0 : GNT_L1;
    end
  end

  // Route the granted address and decode which memory it targets.
  always_comb begin
    gaddr = '0;
    case (gnt_d)
      GNT_CPU: gaddr = bus.cpu_addr;
      GNT_L0:  gaddr = bus.l0_addr;
      GNT_L1:  gaddr = bus.l1_addr;
      default: gaddr = '0;
    endcase
    sel_d  = SEL_NONE;
    if (gnt_d != GNT_NONE) begin
      if (!gaddr[17])
        sel_d = SEL_RAM;
      else if (gaddr[17:12] == 6'b100000)
        sel_d = SEL_ROM;
    end
    lane_d = gaddr[1:0];
  end

  // Round-robin pointer follows the last layer actually granted.
  always_comb begin
    rr_d = rr_q;
    if (gnt_d == GNT_L0)
      rr_d = 1'b0;
    else if (gnt_d == GNT_L1)
      rr_d = 1'b1;
  end

  // Wait counters: count lost eligible cycles, saturate at the limit, hold through ack cycles.
  always_comb begin
    wait0_d = wait0_q;
    if (!bus.l0_strobe || gnt_d == GNT_L0)
      wait0_d = '0;
    else if (elig0 && wait0_q < LIMIT)
      wait0_d = wait0_q + 4'd1;

    wait1_d = wait1_q;
    if (!bus.l1_strobe || gnt_d == GNT_L1)
      wait1_d = '0;
    else if (elig1 && wait1_q < LIMIT)
      wait1_d = wait1_q + 4'd1;
  end

  // State register; reset drops any pending ack and points round-robin at l1.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      gnt_q   <= GNT_NONE;
      sel_q   <= SEL_NONE;
      lane_q  <= 2'd0;
      rr_q    <= 1'b1;
      wait0_q <= 4'd0;
      wait1_q <= 4'd0;
    end else begin
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      lane_q  <= lane_d;
      rr_q    <= rr_d;
      wait0_q <= wait0_d;
      wait1_q <= wait1_d;
    end
  end

  // Memory-side drive: addresses and byte select are zero when nothing is granted.
  assign bus.ram_addr    = gaddr[16:2];
  assign bus.rom_addr    = gaddr[11:2];
  assign bus.ram_bytesel = (gnt_d != GNT_NONE) ? (4'b0001 << gaddr[1:0]) : 4'b0000;
  assign bus.ram_wrdata  = {4{bus.cpu_wrdata}};
  assign bus.ram_write   = (gnt_d == GNT_CPU) && bus.cpu_write && (sel_d == SEL_RAM);

  // Return path: memories answer one cycle later, steered by the registered select.
  always_comb begin
    rd_word = 32'd0;
    if (sel_q == SEL_RAM)
      rd_word = bus.ram_rddata;
    else if (sel_q == SEL_ROM)
      rd_word = bus.rom_rddata;
  end

  // CPU sees only the byte lane it addressed.
  always_comb begin
    cpu_byte = 8'd0;
    case (lane_q)
      2'd0: cpu_byte = rd_word[7:0];
      2'd1: cpu_byte = rd_word[15:8];
      2'd2: cpu_byte = rd_word[23:16];
      2'd3: cpu_byte = rd_word[31:24];
      default: cpu_byte = 8'd0;
    endcase
  end

  assign bus.cpu_ack    = (gnt_q == GNT_CPU);
  assign bus.l0_ack     = (gnt_q == GNT_L0);
  assign bus.l1_ack     = (gnt_q == GNT_L1);
  assign bus.cpu_rddata = cpu_byte;
  assign bus.bus_rddata = rd_word;

  // Only one initiator can be acknowledged per cycle.
  ack_onehot: assert property (@(posedge clk25) disable iff (reset)
    $onehot0({bus.cpu_ack, bus.l0_ack, bus.l1_ack}));

  // Writes only ever come from a CPU grant.
  write_from_cpu: assert property (@(posedge clk25) disable iff (reset)
    bus.ram_write |-> (bus.cpu_strobe && bus.cpu_write));

endmodule
